// File: rtl/moving_average_filter_if.sv
// Sample-stream bundle for the moving-average filter.
// The source drives the input side; the filter drives the output side.
interface moving_average_filter_if #(
  parameter int WIDTH = 8
);
  logic             enb;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             primed;

  modport master (
    output enb, in_valid, in_data, clear,
    input  out_valid, out_data, primed
  );

  modport slave (
    input  enb, in_valid, in_data, clear,
    output out_valid, out_data, primed
  );
endinterface

// File: rtl/moving_average_filter.sv
// Streaming moving average over a 2^LOG2_DEPTH window.
// It keeps a ring-buffer history and a full-precision running sum, with optional round-half-up.
module moving_average_filter #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  moving_average_filter_if.slave bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam logic [SW-1:0]         RND       = (ROUND != 0) ? SW'(DEPTH / 2) : '0;
  localparam logic [LOG2_DEPTH:0]   FILL_FULL = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH:0]   FILL_ONE  = (LOG2_DEPTH + 1)'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE   = LOG2_DEPTH'(1);

  logic [WIDTH-1:0]      r_buf [DEPTH];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [SW-1:0]         r_sum;
  logic [LOG2_DEPTH:0]   r_fill;
  logic                  r_primed;
  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_out_data;

  logic                  w_clear;
  logic                  w_accept;
  logic [WIDTH-1:0]      w_oldest;
  logic [SW-1:0]         w_sum_next;
  logic [LOG2_DEPTH:0]   w_fill_next;
  logic                  w_full;
  logic [WIDTH-1:0]      w_avg;

  assign w_clear     = bus.enb & bus.clear;
  assign w_accept    = bus.enb & bus.in_valid & ~bus.clear;
  assign w_oldest    = r_buf[r_wr_ptr];
  // The slot being overwritten is the oldest sample, or zero while filling, so this never underflows.
  assign w_sum_next  = r_sum + SW'(bus.in_data) - SW'(w_oldest);
  assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_ONE;
  assign w_full      = (w_fill_next == FILL_FULL);
  assign w_avg       = WIDTH'((w_sum_next + RND) >> LOG2_DEPTH);

  // Per-entry registers so that a clear can flush the whole history in one cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_buf[gi] <= '0;
        end else if (w_clear) begin
          r_buf[gi] <= '0;
        end else if (w_accept && (r_wr_ptr == LOG2_DEPTH'(gi))) begin
          r_buf[gi] <= bus.in_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_sum       <= '0;
      r_fill      <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_sum    <= '0;
        r_fill   <= '0;
        r_primed <= 1'b0;
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_sum    <= w_sum_next;
        r_fill   <= w_fill_next;
        r_primed <= w_full;
        if (w_full) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_avg;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.primed    = r_primed;
endmodule

// File: tb/tb_moving_average_filter.sv
// Bench for moving_average_filter: directed 4-tap checks (ROUND=1 and ROUND=0) plus a random
// 8-tap, 10-bit stream (both ROUND values) compared every cycle against a sliding-window model.
module tb_moving_average_filter;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_c;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  moving_average_filter_if #(.WIDTH(8))  if_a ();
  moving_average_filter_if #(.WIDTH(8))  if_b ();
  moving_average_filter_if #(.WIDTH(10)) if_c ();
  moving_average_filter_if #(.WIDTH(10)) if_d ();

  assign if_b.enb      = if_a.enb;
  assign if_b.in_valid = if_a.in_valid;
  assign if_b.in_data  = if_a.in_data;
  assign if_b.clear    = if_a.clear;
  assign if_d.enb      = if_c.enb;
  assign if_d.in_valid = if_c.in_valid;
  assign if_d.in_data  = if_c.in_data;
  assign if_d.clear    = if_c.clear;

  moving_average_filter #(.WIDTH(8), .LOG2_DEPTH(2), .ROUND(1)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  moving_average_filter #(.WIDTH(8), .LOG2_DEPTH(2), .ROUND(0)) dut_b (.clk(clk), .reset(rst_a), .bus(if_b));
  moving_average_filter #(.WIDTH(10), .LOG2_DEPTH(3), .ROUND(1)) dut_c (.clk(clk), .reset(rst_c), .bus(if_c));
  moving_average_filter #(.WIDTH(10), .LOG2_DEPTH(3), .ROUND(0)) dut_d (.clk(clk), .reset(rst_c), .bus(if_d));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  // Reference: the window is simply the last DEPTH accepted samples.
  int qa[$];
  int qc[$];
  bit arm_a = 1'b0, arm_c = 1'b0;
  bit ea_v, ea_p, ec_v, ec_p;
  int ea_d1, ea_d0, ec_d1, ec_d0;

  always @(posedge clk) begin
    if (!rst_a) begin
      qa.delete();
      ea_v <= 1'b0; ea_p <= 1'b0; ea_d1 <= 0; ea_d0 <= 0; arm_a <= 1'b1;
    end else if (!if_a.enb) begin
      ea_v <= 1'b0;
    end else if (if_a.clear) begin
      qa.delete();
      ea_v <= 1'b0; ea_p <= 1'b0;
    end else if (if_a.in_valid) begin
      qa.push_back(int'(if_a.in_data));
      if (qa.size() > 4) void'(qa.pop_front());
      ea_v <= (qa.size() == 4);
      ea_p <= (qa.size() == 4);
      if (qa.size() == 4) begin
        ea_d1 <= (qsum(qa) + 2) / 4;
        ea_d0 <= qsum(qa) / 4;
      end
    end else begin
      ea_v <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_c) begin
      qc.delete();
      ec_v <= 1'b0; ec_p <= 1'b0; ec_d1 <= 0; ec_d0 <= 0; arm_c <= 1'b1;
    end else if (!if_c.enb) begin
      ec_v <= 1'b0;
    end else if (if_c.clear) begin
      qc.delete();
      ec_v <= 1'b0; ec_p <= 1'b0;
    end else if (if_c.in_valid) begin
      qc.push_back(int'(if_c.in_data));
      if (qc.size() > 8) void'(qc.pop_front());
      ec_v <= (qc.size() == 8);
      ec_p <= (qc.size() == 8);
      if (qc.size() == 8) begin
        ec_d1 <= (qsum(qc) + 4) / 8;
        ec_d0 <= qsum(qc) / 8;
      end
    end else begin
      ec_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (arm_a) begin
      chk("A.out_valid", int'(if_a.out_valid), int'(ea_v));
      chk("A.out_data",  int'(if_a.out_data),  ea_d1);
      chk("A.primed",    int'(if_a.primed),    int'(ea_p));
      chk("B.out_valid", int'(if_b.out_valid), int'(ea_v));
      chk("B.out_data",  int'(if_b.out_data),  ea_d0);
      chk("B.primed",    int'(if_b.primed),    int'(ea_p));
    end
    if (arm_c) begin
      chk("C.out_valid", int'(if_c.out_valid), int'(ec_v));
      chk("C.out_data",  int'(if_c.out_data),  ec_d1);
      chk("C.primed",    int'(if_c.primed),    int'(ec_p));
      chk("D.out_valid", int'(if_d.out_valid), int'(ec_v));
      chk("D.out_data",  int'(if_d.out_data),  ec_d0);
      chk("D.primed",    int'(if_d.primed),    int'(ec_p));
    end
  end

  task automatic drive_a(input bit e, input bit v, input int d, input bit c);
    if_a.enb = e; if_a.in_valid = v; if_a.in_data = 8'(d); if_a.clear = c;
    @(posedge clk);
    @(negedge clk);
    if_a.enb = 1'b1; if_a.in_valid = 1'b0; if_a.clear = 1'b0;
  endtask

  task automatic acc(input int d);
    drive_a(1'b1, 1'b1, d, 1'b0);
    $display("A accept %0d -> out_valid=%0d out_data=%0d/%0d primed=%0d",
             d, if_a.out_valid, if_a.out_data, if_b.out_data, if_a.primed);
  endtask

  task automatic directed();
    int fills[4] = '{4, 8, 12, 16};
    rst_a = 1'b0;
    if_a.enb = 1'b1; if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.clear = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.out_valid", int'(if_a.out_valid), 0);
    chk("reset.out_data",  int'(if_a.out_data),  0);
    chk("reset.primed",    int'(if_a.primed),    0);
    rst_a = 1'b1;

    // Fill and steady state
    acc(4);  chk("fill1.valid", int'(if_a.out_valid), 0);
    acc(8);  chk("fill2.valid", int'(if_a.out_valid), 0);
    acc(12); chk("fill3.primed", int'(if_a.primed), 0);
    acc(16);
    chk("fill4.valid",  int'(if_a.out_valid), 1);
    chk("fill4.data",   int'(if_a.out_data),  10);
    chk("fill4.primed", int'(if_a.primed),    1);
    acc(20); chk("steady.data", int'(if_a.out_data), 14);

    // Full scale and wrap
    repeat (4) acc(255);
    chk("full.data", int'(if_a.out_data), 255);
    acc(0); chk("drain1.data", int'(if_a.out_data), 191);
    acc(0); chk("drain2.data", int'(if_a.out_data), 128);
    acc(0); chk("drain3.data", int'(if_a.out_data), 64);
    acc(0); chk("drain4.data", int'(if_a.out_data), 0);

    // Rounding: sum 6 rounds up, sum 5 does not
    acc(1); acc(1); acc(2); acc(2);
    chk("round6.r1", int'(if_a.out_data), 2);
    chk("round6.r0", int'(if_b.out_data), 1);
    acc(1); acc(1); acc(1); acc(2);
    chk("round5.r1", int'(if_a.out_data), 1);
    chk("round5.r0", int'(if_b.out_data), 1);

    // Gaps and enable-low with stray inputs
    drive_a(1'b1, 1'b0, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      acc(k < 4 ? fills[k] : 20);
      repeat (3) begin
        drive_a(1'b1, 1'b0, 77, 1'b0);
        chk("gap.valid", int'(if_a.out_valid), 0);
      end
      drive_a(1'b0, 1'b1, 99, 1'b1);
      chk("enb0.valid", int'(if_a.out_valid), 0);
      chk("enb0.held", int'(if_a.out_data), k < 3 ? 1 : (k == 3 ? 10 : 14));
    end

    // Clear beats a coincident sample
    drive_a(1'b1, 1'b1, 200, 1'b1);
    chk("clr.primed", int'(if_a.primed),    0);
    chk("clr.valid",  int'(if_a.out_valid), 0);
    chk("clr.held",   int'(if_a.out_data),  14);
    acc(8); acc(8); acc(8);
    chk("refill3.valid", int'(if_a.out_valid), 0);
    acc(8);
    chk("refill4.valid", int'(if_a.out_valid), 1);
    chk("refill4.data",  int'(if_a.out_data),  8);

    // Reset mid-window, with enb low
    acc(100); acc(50);
    rst_a = 1'b0;
    drive_a(1'b0, 1'b0, 0, 1'b0);
    chk("midrst.valid",  int'(if_a.out_valid), 0);
    chk("midrst.data",   int'(if_a.out_data),  0);
    chk("midrst.primed", int'(if_a.primed),    0);
    rst_a = 1'b1;
    acc(4); acc(4); acc(4);
    chk("post_rst3.valid", int'(if_a.out_valid), 0);
    acc(6);
    chk("post_rst4.data", int'(if_a.out_data), 5);
  endtask

  task automatic random_stream();
    int pulses = 0;
    rst_c = 1'b0;
    if_c.enb = 1'b0; if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_c = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      if_c.enb      = ($urandom_range(0, 7) != 0);
      if_c.in_valid = ($urandom_range(0, 3) != 0);
      if_c.clear    = ($urandom_range(0, 199) == 0);
      if_c.in_data  = (sel == 0) ? 10'd1023 : (sel == 1) ? 10'd0 : 10'($urandom_range(0, 1023));
      rst_c         = ($urandom_range(0, 999) != 0);
      @(posedge clk);
      @(negedge clk);
      if (if_c.out_valid) begin
        pulses++;
        if (pulses % 1000 == 0)
          $display("C/D pulse %0d: out_data=%0d/%0d", pulses, if_c.out_data, if_d.out_data);
      end
    end
    chk("rand.pulses_seen", int'(pulses > 100), 1);
  endtask

  initial begin
    fork
      directed();
      random_stream();
    join
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/moving_average_filter.md
# moving_average_filter

Parametrised streaming moving-average filter: the next generation of the team's fixed 4-tap smoothing filter. It keeps a 2^LOG2_DEPTH-sample history in a ring buffer with a full-precision running sum, so there is no per-sample pre-divide truncation. It adds an optional round-to-nearest, an in_valid qualifier, a window-primed indication and a synchronous history clear. It sits in the pixel/sample path ahead of the edge-detection stages, in place of the fixed smoother.

## Interface
- WIDTH, 8: sample width in bits, unsigned.
- LOG2_DEPTH, 2: window length DEPTH = 2^LOG2_DEPTH; legal range 1..6.
- ROUND, 1: 1 = round half up on the divide; 0 = truncate.

- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (reset == 0 resets on the next rising clk edge).
- enb  in  1  clock enable; when 0, all state holds.
- in_valid  in  1  in_data carries a sample this cycle.
- in_data  in  WIDTH  input sample.
- clear  in  1  synchronous history flush, qualified by enb.
- out_valid  out  1  one-cycle pulse: out_data is a valid full-window average.
- out_data  out  WIDTH  averaged output; holds its last value between pulses.
- primed  out  1  high once DEPTH samples have been accepted since the last reset or clear.

## Operation
- Accept = enb & in_valid & ~clear & reset.
- Internal state:
  - buf[0..DEPTH-1], WIDTH bits each.
  - wr_ptr, LOG2_DEPTH bits.
  - sum, WIDTH+LOG2_DEPTH bits.
  - fill_cnt, saturating 0..DEPTH.
- On accept:
  - sum_next = sum + in_data - buf[wr_ptr].
  - buf[wr_ptr] <= in_data.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
  - fill_cnt increments, saturating at DEPTH.
- Arithmetic: buf[wr_ptr] is always the oldest sample, or 0 during fill, so sum never underflows. sum never exceeds DEPTH*(2^WIDTH-1), so no overflow and no saturation logic.
- Output calculation:
  - avg = (sum_next + (ROUND ? DEPTH/2 : 0)) >> LOG2_DEPTH.
  - The intermediate fits in WIDTH+LOG2_DEPTH bits.
  - avg <= 2^WIDTH-1 always.
- out_valid, out_data update only on an accept whose post-increment fill count equals DEPTH:
  - out_valid <= 1 and out_data <= avg.
  - Samples 1..DEPTH-1 after reset or clear produce no output pulse.
- Any cycle without such an accept: out_valid <= 0; out_data holds.
- Clear (enb & clear):
  - Zeroes buf, sum, wr_ptr, fill_cnt and primed.
  - out_valid <= 0; out_data holds.
  - Clear takes priority over a coincident sample, which is dropped.
- enb = 0: all state and out_data hold; out_valid <= 0; clear and in_valid are ignored.
- Reset (reset == 0, any enb):
  - buf, sum, wr_ptr, fill_cnt = 0.
  - out_valid = 0, out_data = 0, primed = 0.
  - Reset mid-window discards the history; the next DEPTH accepts refill the window.

## Timing
- Latency: 1 cycle. A sample accepted at edge k gives out_valid/out_data valid after edge k, sampled by a consumer at edge k+1.
- Throughput: one sample per cycle, no back-pressure; in_valid may toggle arbitrarily.
- primed is registered; it rises on the same edge as the first out_valid.
- No combinational path from inputs to outputs.

## Test plan
- Fill and steady state (WIDTH=8, LOG2_DEPTH=2, ROUND=1):
  - Accept 4, 8, 12, 16 on consecutive cycles -> out_valid only after the 4th; out_data=10 ((40+2)>>2); primed rises with it.
  - Then accept 20 -> sum 56, out_data=14.
- Full-scale and wrap:
  - 255 x4 -> 255.
  - Then 0 -> sum 765, out_data=191.
  - Then 0,0,0 -> 128, 64, 0, with wr_ptr wrapping twice and no sum underflow.
- Rounding:
  - Window 1,1,2,2 (sum 6) -> out_data=2 with ROUND=1; 1 with ROUND=0.
  - Window 1,1,1,2 (sum 5) -> 1 in both builds.
- Gaps and enable:
  - Samples with in_valid low for 3 cycles between accepts, and with enb low while in_valid=1 -> no state change, out_valid=0 in gap cycles, out_data held.
  - Averages are identical to the gap-free stream.
- Clear and reset:
  - clear asserted with a sample of 200 after a primed window -> sample dropped, primed=0, out_data held.
  - Next 4 accepts of 8 -> single pulse, out_data=8.
  - reset=0 mid-window -> all outputs 0 after the edge.
- Randomised long stream (LOG2_DEPTH=3, WIDTH=10, both ROUND values), 10k samples with random in_valid, enb and rare clear -> out_data matches a reference model every pulse.
